// File: rtl/fb_pkg.sv
// Shared frame-buffer types and constants for the NES 256x240 frame buffer write path.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 256;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned FB_ADDR_W = 16;

  // Address of the bottom-right pixel (255,239); marks the end of a frame.
  localparam logic [FB_ADDR_W-1:0] FB_LAST_ADDR = FB_ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  typedef logic [5:0] nes_pix_t;

  typedef struct packed {
    nes_pix_t               data;
    logic [FB_ADDR_W-1:0]   addr;
  } fb_wr_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    STALL
  } fbw_state_e;

  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [7:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/fbw_fifo.sv
// Synchronous pixel-write FIFO; DEPTH must be a power of two, at least 2.
module fbw_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fb_wr_t                   push_data,
  input  logic                     pop,
  output fb_wr_t                   pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fb_wr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Frame-buffer write side: queues PPU pixels and writes them to RAM when the display port is idle.
// Optional double buffering is enabled by defining FB_DOUBLE_BUFFER_EN.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FB_LINES   = FB_HEIGHT
) (
  input  logic                  vga_clock,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [5:0]            pix_data,
  input  logic [7:0]            pix_x,
  input  logic [7:0]            pix_y,
  input  logic                  rd_busy,
  output logic                  wr_en,
  output logic [FB_ADDR_W-1:0]  wr_addr,
  output logic [5:0]            wr_data,
  output logic [7:0]            drop_cnt
`ifdef FB_DOUBLE_BUFFER_EN
  ,
  output logic                  wr_bank,
  output logic                  disp_bank
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fbw_state_e       state;
  fbw_state_e       state_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fb_wr_t           entry_c;
  fb_wr_t           head_c;
  logic             accept_c;
  logic             in_range_c;
  logic             push_c;
  logic             pop_c;

  assign pix_ready  = !fifo_full;
  assign accept_c   = pix_valid && pix_ready;
  assign in_range_c = (32'(pix_y) < FB_LINES);
  assign push_c     = accept_c && in_range_c;

  always_comb begin
    entry_c      = '0;
    entry_c.data = pix_data;
    entry_c.addr = fb_addr(pix_x, pix_y);
  end

  fbw_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (vga_clock),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (entry_c),
    .pop       (pop_c),
    .pop_data  (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge vga_clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A pop always means a write next cycle; rd_busy at the edge vetoes it.
  always_comb begin
    state_next = state;
    pop_c      = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          if (rd_busy) begin
            state_next = STALL;
          end else begin
            pop_c      = 1'b1;
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        if (fifo_empty) begin
          state_next = IDLE;
        end else if (rd_busy) begin
          state_next = STALL;
        end else begin
          pop_c = 1'b1;
        end
      end
      STALL: begin
        if (!rd_busy) begin
          pop_c      = 1'b1;
          state_next = WRITE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/data hold their last value between writes.
  always_ff @(posedge vga_clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= pop_c;
      if (pop_c) begin
        wr_addr <= head_c.addr;
        wr_data <= head_c.data;
      end
    end
  end

  always_ff @(posedge vga_clock or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (accept_c && !in_range_c && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  // Banks swap on the edge after the last pixel of a frame is written.
  always_ff @(posedge vga_clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      disp_bank <= 1'b1;
    end else if (wr_en && (wr_addr == FB_LAST_ADDR)) begin
      wr_bank   <= !wr_bank;
      disp_bank <= wr_bank;
    end
  end
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Randomized self-checking bench for frame_buffer_writer against a queue-based reference model.
module tb_frame_buffer_writer;
  import fb_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LINES = 240;

  logic        vga_clock = 1'b0;
  logic        rst_n     = 1'b0;
  logic        pix_valid = 1'b0;
  logic        rd_busy   = 1'b0;
  logic [5:0]  pix_data  = '0;
  logic [7:0]  pix_x     = '0;
  logic [7:0]  pix_y     = '0;
  logic        pix_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [5:0]  wr_data;
  logic [7:0]  drop_cnt;
`ifdef FB_DOUBLE_BUFFER_EN
  logic        wr_bank;
  logic        disp_bank;
`endif

  frame_buffer_writer #(
    .FIFO_DEPTH (DEPTH),
    .FB_LINES   (LINES)
  ) dut (
    .vga_clock (vga_clock),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .drop_cnt  (drop_cnt)
`ifdef FB_DOUBLE_BUFFER_EN
    ,
    .wr_bank   (wr_bank),
    .disp_bank (disp_bank)
`endif
  );

  always #5 vga_clock = ~vga_clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted in-range pixels; one pop per edge when rd_busy is low.
  fb_wr_t      q[$];
  logic        m_wr_en    = 1'b0;
  logic [15:0] m_addr     = '0;
  logic [5:0]  m_data     = '0;
  int          m_drop     = 0;
  logic        m_busy_prev = 1'b0;
  logic        m_wbank    = 1'b0;
  logic        m_dbank    = 1'b1;

  initial begin : model
    fb_wr_t h;
    fb_wr_t e;
    bit     acc;
    forever begin
      @(posedge vga_clock or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_wr_en = 1'b0; m_addr = '0; m_data = '0; m_drop = 0;
        m_busy_prev = 1'b0; m_wbank = 1'b0; m_dbank = 1'b1;
      end else begin
        if (m_wr_en && m_addr == 16'hEFFF) begin
          m_dbank = m_wbank;
          m_wbank = !m_wbank;
        end
        acc = pix_valid && (q.size() < DEPTH);
        if (q.size() > 0 && !rd_busy) begin
          h = q.pop_front();
          m_wr_en = 1'b1; m_addr = h.addr; m_data = h.data;
        end else begin
          m_wr_en = 1'b0;
        end
        if (acc) begin
          if (int'(pix_y) >= LINES) begin
            if (m_drop < 255) m_drop++;
          end else begin
            e.data = pix_data;
            e.addr = 16'(int'(pix_y) * 256 + int'(pix_x));
            q.push_back(e);
          end
        end
        m_busy_prev = rd_busy;
      end
    end
  end

  bit          chk_on = 1'b0;
  int          wr_cnt = 0;
  logic [15:0] last_wr_addr = '0;

  initial begin : compare
    forever begin
      @(negedge vga_clock);
      if (rst_n && chk_on) begin
        chk("wr_en", 32'(wr_en), 32'(m_wr_en));
        chk("wr_addr", 32'(wr_addr), 32'(m_addr));
        chk("wr_data", 32'(wr_data), 32'(m_data));
        chk("pix_ready", 32'(pix_ready), 32'(q.size() < DEPTH));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("write_after_busy", 32'(wr_en & m_busy_prev), 32'd0);
`ifdef FB_DOUBLE_BUFFER_EN
        chk("wr_bank", 32'(wr_bank), 32'(m_wbank));
        chk("disp_bank", 32'(disp_bank), 32'(m_dbank));
`endif
      end
      if (wr_en) begin
        wr_cnt++;
        last_wr_addr = wr_addr;
      end
    end
  end

  int busy_mode = 0;
  bit busy_tgl  = 1'b0;

  function automatic logic pick_busy();
    case (busy_mode)
      0: return 1'b0;
      1: return 1'b1;
      2: begin busy_tgl = !busy_tgl; return busy_tgl; end
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  // Hold one pixel on the bus until it transfers or max_cyc cycles elapse.
  task automatic present(input logic [7:0] x, input logic [7:0] y, input logic [5:0] d,
                         input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      @(negedge vga_clock);
      rd_busy = pick_busy();
      pix_valid = 1'b1; pix_x = x; pix_y = y; pix_data = d;
      ok = pix_ready;
      @(posedge vga_clock);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge vga_clock);
      pix_valid = 1'b0;
      rd_busy = pick_busy();
    end
  endtask

  task automatic rand_stream(input int n, input bit gaps, input bit drops);
    bit ok;
    logic [7:0] y;
    for (int i = 0; i < n; i++) begin
      y = (drops && $urandom_range(0, 9) == 0) ? 8'($urandom_range(240, 255))
                                               : 8'($urandom_range(0, 239));
      present(8'($urandom_range(0, 255)), y, 6'($urandom_range(0, 63)), 200, ok);
      chk("accept", 32'(ok), 32'd1);
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  initial begin : stim
    bit ok;
    int w0;
    bit ready_dropped;

    // Reset values
    #12;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ready", 32'(pix_ready), 32'd1);
`ifdef FB_DOUBLE_BUFFER_EN
    chk("rst_wr_bank", 32'(wr_bank), 32'd0);
    chk("rst_disp_bank", 32'(disp_bank), 32'd1);
`endif
    @(negedge vga_clock);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Single pixel latency: write visible after the second edge
    present(8'd3, 8'd2, 6'h21, 4, ok);
    @(negedge vga_clock);
    pix_valid = 1'b0;
    chk("t1_no_early_write", 32'(wr_en), 32'd0);
    @(negedge vga_clock);
    chk("t1_wr_en", 32'(wr_en), 32'd1);
    chk("t1_wr_addr", 32'(wr_addr), 32'h0203);
    chk("t1_wr_data", 32'(wr_data), 32'h21);
    idle(3);

    // Back-to-back stream with the RAM free
    w0 = wr_cnt;
    ready_dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      present(8'(i), 8'(i * 7), 6'(i + 1), 1, ok);
      if (!ok) ready_dropped = 1'b1;
    end
    idle(5);
    chk("t2_ready_held", 32'(ready_dropped), 32'd0);
    chk("t2_writes", 32'(wr_cnt - w0), 32'd20);

    // Display owns the RAM: fill the FIFO, then release
    busy_mode = 1;
    w0 = wr_cnt;
    for (int i = 0; i < 16; i++) begin
      present(8'(100 + i), 8'(50), 6'(i), 1, ok);
      chk("t3_accept", 32'(ok), 32'd1);
    end
    present(8'(116), 8'(50), 6'(16), 4, ok);
    chk("t3_full_blocks", 32'(ok), 32'd0);
    chk("t3_ready_low", 32'(pix_ready), 32'd0);
    chk("t3_no_write", 32'(wr_cnt - w0), 32'd0);
    busy_mode = 0;
    for (int i = 16; i < 20; i++) begin
      present(8'(100 + i), 8'(50), 6'(i), 50, ok);
      chk("t3_accept_late", 32'(ok), 32'd1);
    end
    idle(25);
    chk("t3_writes", 32'(wr_cnt - w0), 32'd20);

    // rd_busy toggling every cycle
    busy_mode = 2;
    rand_stream(30, 1'b0, 1'b0);
    busy_mode = 0;
    idle(25);

    // Out-of-range scanlines and drop counter saturation
    w0 = wr_cnt;
    present(8'd10, 8'd240, 6'h3, 4, ok);
    present(8'd11, 8'd241, 6'h4, 4, ok);
    idle(3);
    chk("t5_drop2", 32'(drop_cnt), 32'd2);
    chk("t5_no_write", 32'(wr_cnt - w0), 32'd0);
    for (int i = 0; i < 300; i++) begin
      present(8'($urandom_range(0, 255)), 8'($urandom_range(240, 255)), 6'(i), 4, ok);
    end
    idle(3);
    chk("t5_drop_sat", 32'(drop_cnt), 32'hFF);

    // Last pixel of the frame
    present(8'd255, 8'd239, 6'h2A, 4, ok);
    idle(4);
    chk("t6_last_addr", 32'(last_wr_addr), 32'hEFFF);
`ifdef FB_DOUBLE_BUFFER_EN
    chk("t6_wr_bank", 32'(wr_bank), 32'd1);
    chk("t6_disp_bank", 32'(disp_bank), 32'd0);
`endif

    // Random mix with random display contention and gaps
    busy_mode = 3;
    rand_stream(200, 1'b1, 1'b1);
    busy_mode = 0;
    idle(30);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 6; i++) present(8'(i), 8'(9), 6'(i), 4, ok);
    #2;
    chk("pre_reset_wr_en", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr_en", 32'(wr_en), 32'd0);
    chk("async_rst_ready", 32'(pix_ready), 32'd1);
    chk("async_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge vga_clock);
    pix_valid = 1'b0;
    repeat (2) @(negedge vga_clock);
    rst_n = 1'b1;
    w0 = wr_cnt;
    idle(10);
    chk("post_reset_no_write", 32'(wr_cnt - w0), 32'd0);
    rand_stream(20, 1'b0, 1'b0);
    idle(25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
